// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
//   Bundles the request/grant handshake between the four mux requesters and
//   the round-robin arbiter that drives the shared 4-to-1 mux select lines.
//
//   req    [3:0]  request vector, bit i = requester i (0->a, 1->b, 2->c, 3->d)
//   done          current holder finishes its tenure early
//   grant  [3:0]  registered one-hot grant, all zero when idle
//   s0, s1        registered mux select LSB / MSB (index of the granted input)
//   busy          high while a grant is active
//
//   master : requester side (drives req/done, observes grant and selects)
//   slave  : arbiter side
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       s0;
  logic       s1;
  logic       busy;

  modport master (
    output req,
    output done,
    input  grant,
    input  s0,
    input  s1,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output s0,
    output s1,
    output busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter sharing one 4-to-1 mux among four requesters. It
//   issues a registered one-hot grant and the matching select pair {s1,s0},
//   limits every tenure to MAX_HOLD cycles, and hands the mux straight to the
//   next winner on release so there is no idle cycle between tenures.
//
//   Parameters
//     MAX_HOLD  longest tenure in cycles (1..255)
//     CNT_W     hold counter width, 2**CNT_W must exceed MAX_HOLD
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   mux_rr_arbiter_if.slave (req, done in; grant, s0, s1, busy out)
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mux_rr_arbiter_if.slave         bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q,    state_d;
  logic [1:0]       ptr_q,      ptr_d;
  logic [1:0]       gidx_q,     gidx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       grant_q,    grant_d;
  logic [1:0]       sel_q,      sel_d;

  // Release of the current tenure: holder dropped its request, signalled
  // done, or has been visible for MAX_HOLD cycles. Only meaningful in GRANT.
  logic       release_w;
  logic [1:0] scan_ptr;
  logic [3:0] rot_req;
  logic       win_found;
  logic [1:0] win_off;
  logic [1:0] win_idx;

  assign release_w = (state_q == GRANT) &&
                     (!bus.req[gidx_q] || bus.done || (hold_cnt_q == HOLD_LAST));

  // On release the search starts just past the holder, so the holder gets the
  // lowest priority but can still win again if nobody else is asking.
  assign scan_ptr = release_w ? (gidx_q + 2'd1) : ptr_q;

  // Rotate req so that bit 0 is the highest-priority candidate; a plain
  // lowest-bit-first priority encoder then implements the cyclic scan.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = bus.req[scan_ptr + 2'(gi)];
  end

  always_comb begin
    win_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_off = 2'(k);
      end
    end
  end

  assign win_found = |rot_req;
  assign win_idx   = scan_ptr + win_off;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      gidx_q     <= 2'd0;
      hold_cnt_q <= '0;
      grant_q    <= 4'b0000;
      sel_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          gidx_d     = win_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_w) begin
          ptr_d      = gidx_q + 2'd1;
          hold_cnt_d = '0;
          if (win_found) begin
            gidx_d = win_idx;
          end else begin
            state_d = IDLE;
          end
        end else begin
          // Cannot wrap: release fires at MAX_HOLD-1 before reaching the top.
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: registered grant and select follow the next state. The
  // select pair keeps its last value while idle so the mux output is steady.
  always_comb begin
    grant_d = 4'b0000;
    sel_d   = sel_q;
    if (state_d == GRANT) begin
      grant_d = 4'b0001 << gidx_d;
      sel_d   = gidx_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.s0    = sel_q[0];
  assign bus.s1    = sel_q[1];
  assign bus.busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three instances cover the default tenure, a short tenure and the
  // single-cycle rotation corner; all see the same req/done/rst.
  mux_rr_arbiter_if if8 ();
  mux_rr_arbiter_if if4 ();
  mux_rr_arbiter_if if1 ();

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  mux_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       busy;
    logic [1:0] gidx;
    logic [1:0] ptr;
    logic [1:0] sel;
    logic [8:0] ten;   // cycles the current grant has been visible
  } mst_t;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;   // {s1,s0}
    logic       busy;
  } obs_t;

  typedef struct packed {
    obs_t e8;
    obs_t e4;
    obs_t e1;
  } exp_t;

  mst_t m8 = '0;
  mst_t m4 = '0;
  mst_t m1 = '0;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  bit mon_en  = 1'b0;
  bit inv_bad = 1'b0;
  time inv_time = 0;

  function automatic mst_t model_step(mst_t s, logic [3:0] r, logic d, logic rs, int mh);
    mst_t n;
    logic rel;
    logic hit;
    logic [1:0] start;
    logic [1:0] c;
    n = s;
    if (rs) begin
      n = '0;
      return n;
    end
    rel = !s.busy || !r[s.gidx] || d || (int'(s.ten) == mh);
    if (!rel) begin
      n.ten = s.ten + 9'd1;
      return n;
    end
    start = s.busy ? (s.gidx + 2'd1) : s.ptr;
    if (s.busy) n.ptr = start;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c = start + 2'(k);
      if (!hit && r[c]) begin
        hit    = 1'b1;
        n.gidx = c;
      end
    end
    if (hit) begin
      n.busy = 1'b1;
      n.sel  = n.gidx;
      n.ten  = 9'd1;
    end else begin
      n.busy = 1'b0;
      n.ten  = 9'd0;
    end
    return n;
  endfunction

  function automatic obs_t model_out(mst_t s);
    obs_t o;
    o.grant = s.busy ? (4'b0001 << s.gidx) : 4'b0000;
    o.sel   = s.sel;
    o.busy  = s.busy;
    return o;
  endfunction

  function automatic obs_t read_obs8();
    obs_t o;
    o = {if8.grant, if8.s1, if8.s0, if8.busy};
    return o;
  endfunction

  function automatic exp_t read_all();
    exp_t o;
    o.e8 = {if8.grant, if8.s1, if8.s0, if8.busy};
    o.e4 = {if4.grant, if4.s1, if4.s0, if4.busy};
    o.e1 = {if1.grant, if1.s1, if1.s0, if1.busy};
    return o;
  endfunction

  function automatic bit inv_ok(logic [3:0] g, logic s1, logic s0, logic b);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) if (g[k]) idx = 2'(k);
    if (!$onehot0(g)) return 1'b0;
    if (b !== (|g)) return 1'b0;
    if (b && ({s1, s0} !== idx)) return 1'b0;
    return 1'b1;
  endfunction

  // Structural invariants sampled every cycle once the design is out of reset.
  always @(negedge clk) begin
    if (mon_en && !inv_bad) begin
      if (!inv_ok(if8.grant, if8.s1, if8.s0, if8.busy) ||
          !inv_ok(if4.grant, if4.s1, if4.s0, if4.busy) ||
          !inv_ok(if1.grant, if1.s1, if1.s0, if1.busy)) begin
        inv_bad  <= 1'b1;
        inv_time <= $time;
      end
    end
  end

  // Drive one cycle of stimulus, push the model's expectation, step the clock.
  task automatic tick(input logic [3:0] r, input logic d, input logic rs);
    exp_t e;
    rst      = rs;
    if8.req  = r;  if4.req  = r;  if1.req  = r;
    if8.done = d;  if4.done = d;  if1.done = d;
    m8 = model_step(m8, r, d, rs, 8);
    m4 = model_step(m4, r, d, rs, 4);
    m1 = model_step(m1, r, d, rs, 1);
    e.e8 = model_out(m8);
    e.e4 = model_out(m4);
    e.e1 = model_out(m1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    $display("t=%0t req=%b done=%b rst=%b | g8=%b s8=%b%b | g4=%b s4=%b%b | g1=%b s1=%b%b",
             $time, r, d, rs, if8.grant, if8.s1, if8.s0,
             if4.grant, if4.s1, if4.s0, if1.grant, if1.s1, if1.s0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_t e;
    exp_t o;
    obs_t d8;
    tick(4'b0000, 1'b0, 1'b1);
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick(4'b0000, 1'b0, 1'b0);
      e = sb.pop_front();
      o = read_all();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_sb cycle %0d: got %h expected %h", i, o, e);
      end
      d8 = read_obs8();
      checks++;
      if (d8 !== 7'b0000_00_0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got grant/sel/busy %b expected 0000000", i, d8);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    exp_t o;
    obs_t d8;
    tick(4'b0000, 1'b0, 1'b1);
    void'(sb.pop_front());
    tick(4'b0100, 1'b0, 1'b0);
    e = sb.pop_front();
    o = read_all();
    d8 = read_obs8();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL single_grant_sb: got %h expected %h", o, e);
    end
    checks++;
    if (d8 !== 7'b0100_10_1) begin
      errors++;
      $display("FAIL single_grant: got %b expected 0100101", d8);
    end
    tick(4'b0000, 1'b0, 1'b0);
    e = sb.pop_front();
    o = read_all();
    d8 = read_obs8();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL single_release_sb: got %h expected %h", o, e);
    end
    checks++;
    if (d8 !== 7'b0000_10_0) begin
      errors++;
      $display("FAIL single_release_sel_hold: got %b expected 0000100", d8);
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    exp_t o;
    logic [3:0] w8, w4, w1;
    tick(4'b0000, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 1; k <= 40; k++) begin
      tick(4'b1111, 1'b0, 1'b0);
      e = sb.pop_front();
      o = read_all();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rotation_sb cycle %0d: got %h expected %h", k, o, e);
      end
      w8 = 4'b0001 << (((k - 1) / 8) % 4);
      w4 = 4'b0001 << (((k - 1) / 4) % 4);
      w1 = 4'b0001 << ((k - 1) % 4);
      checks++;
      if ({if8.grant, if4.grant, if1.grant, if8.busy} !== {w8, w4, w1, 1'b1}) begin
        errors++;
        $display("FAIL rotation cycle %0d: got g8=%b g4=%b g1=%b busy8=%b expected %b %b %b 1",
                 k, if8.grant, if4.grant, if1.grant, if8.busy, w8, w4, w1);
      end
    end
  endtask

  task automatic test_done();
    exp_t e;
    exp_t o;
    obs_t d8;
    obs_t want [5];
    logic dn   [5];
    want[0] = 7'b0010_01_1; dn[0] = 1'b0;
    want[1] = 7'b0010_01_1; dn[1] = 1'b0;
    want[2] = 7'b0010_01_1; dn[2] = 1'b0;
    want[3] = 7'b1000_11_1; dn[3] = 1'b1;
    want[4] = 7'b0010_01_1; dn[4] = 1'b1;
    tick(4'b0000, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      tick(4'b1010, dn[i], 1'b0);
      e = sb.pop_front();
      o = read_all();
      d8 = read_obs8();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL done_sb step %0d: got %h expected %h", i, o, e);
      end
      checks++;
      if (d8 !== want[i]) begin
        errors++;
        $display("FAIL done_handoff step %0d: got %b expected %b", i, d8, want[i]);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    exp_t o;
    tick(4'b0000, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 1; k <= 13; k++) begin
      tick(4'b0100, 1'b0, 1'b0);
      e = sb.pop_front();
      o = read_all();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout_sb cycle %0d: got %h expected %h", k, o, e);
      end
      checks++;
      if ({if4.grant, if4.s1, if4.s0, if4.busy, if1.grant, if1.busy} !== {7'b0100_10_1, 5'b0100_1}) begin
        errors++;
        $display("FAIL timeout_reissue cycle %0d: got g4=%b s=%b%b busy4=%b g1=%b busy1=%b expected 0100 10 1 0100 1",
                 k, if4.grant, if4.s1, if4.s0, if4.busy, if1.grant, if1.busy);
      end
    end
  endtask

  task automatic test_reset_midgrant();
    exp_t e;
    exp_t o;
    tick(4'b0000, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 1; k <= 26; k++) begin
      tick(4'b1111, 1'b0, 1'b0);
      void'(sb.pop_front());
    end
    checks++;
    if (if8.grant !== 4'b1000) begin
      errors++;
      $display("FAIL midgrant_setup: got %b expected 1000", if8.grant);
    end
    tick(4'b1111, 1'b0, 1'b1);
    e = sb.pop_front();
    o = read_all();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL midgrant_reset_sb: got %h expected %h", o, e);
    end
    checks++;
    if (o !== 21'd0) begin
      errors++;
      $display("FAIL midgrant_reset: got %h expected 000000", o);
    end
    tick(4'b1111, 1'b0, 1'b0);
    e = sb.pop_front();
    o = read_all();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL after_reset_sb: got %h expected %h", o, e);
    end
    checks++;
    if ({if8.grant, if4.grant, if1.grant} !== 12'b0001_0001_0001) begin
      errors++;
      $display("FAIL after_reset_grant: got %b %b %b expected 0001 0001 0001",
               if8.grant, if4.grant, if1.grant);
    end
  endtask

  task automatic test_random();
    exp_t e;
    exp_t o;
    logic [3:0] r;
    logic d;
    logic rs;
    tick(4'b0000, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 0; k < 300; k++) begin
      r  = 4'($urandom_range(0, 15)) | ((k % 37 < 20) ? 4'b1111 : 4'b0000);
      d  = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 63) == 0);
      tick(r, d, rs);
      e = sb.pop_front();
      o = read_all();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random_sb cycle %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_bad !== 1'b0) begin
      errors++;
      $display("FAIL invariants: violation at t=%0t (got flag %b expected 0)", inv_time, inv_bad);
    end
  endtask

  initial begin
    rst      = 1'b1;
    if8.req  = 4'b0000; if4.req  = 4'b0000; if1.req  = 4'b0000;
    if8.done = 1'b0;    if4.done = 1'b0;    if1.done = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_done();
    test_timeout();
    test_reset_midgrant();
    test_random();
    @(negedge clk);
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 mux datapath among four requesters.
- It drives the mux select pair s0/s1 and a one-hot grant vector.
- It bounds each tenure with a hold timeout and hands off between requesters with no idle bubble.
- It sits in front of the NAND-based and tri-state 4-to-1 mux instances; the mux data inputs a,b,c,d are owned by requesters 0..3.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant (legal range 1..255).
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i] = requester i wants the mux (i=0→a, 1→b, 2→c, 3→d).
- done  input  1  current grant holder finishes early; ignored when no grant is active.
- grant  output  4  one-hot registered grant; all zero when idle.
- s0  output  1  mux select LSB, registered; equals bit 0 of granted index.
- s1  output  1  mux select MSB, registered; equals bit 1 of granted index.
- busy  output  1  high while any grant is active.

Behaviour:
- State machine has two states, IDLE and GRANT. Internal state:
  - ptr (2 bits): highest-priority index for the next arbitration.
  - gidx (2 bits): current holder.
  - hold_cnt (CNT_W bits).
- Reset (rst high at a rising edge) forces: state=IDLE, grant=0000, s0=0, s1=0, busy=0, ptr=0, hold_cnt=0. Reset overrides every other input, including mid-grant; outputs take reset values on the edge after rst is sampled high.
- Arbitration function: scan req cyclically starting at ptr (ptr, ptr+1, ..., ptr+3 mod 4). The first set bit wins.
- IDLE:
  - If any req bit is set, on the next edge go to GRANT with grant=onehot(winner), {s1,s0}=winner, busy=1, hold_cnt=0.
  - Latency is 1 cycle from sampled req to visible grant.
  - If no req bit is set, stay in IDLE; grant=0, busy=0, and s1/s0 hold their last value so the mux output does not glitch.
- GRANT: hold_cnt increments by 1 each cycle. The release condition is any of:
  - (a) req[gidx]=0;
  - (b) done=1;
  - (c) hold_cnt==MAX_HOLD-1, i.e. the grant has been visible for MAX_HOLD cycles.
  - Simultaneous conditions act as one release.
- On release:
  - Set ptr=gidx+1 mod 4.
  - Re-arbitrate on the current req with the new ptr, so the releasing requester has lowest priority but remains eligible if it still asserts req.
  - If a winner exists: direct handoff on the next edge with grant=onehot(winner), s1/s0 updated, hold_cnt=0, busy stays 1 (no bubble).
  - If no winner: go to IDLE with grant=0 and busy=0; s1/s0 hold.
- If no release condition holds, grant, s0/s1 and busy are unchanged.
- Requests from non-holders never pre-empt the current holder before a release condition.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, giving pure per-cycle rotation under full load.
- Invariants (assert in bench):
  - grant is zero or one-hot;
  - busy == |grant;
  - when busy=1, {s1,s0} == index of the set grant bit.
- hold_cnt never exceeds MAX_HOLD-1; no wrap-around is possible.

Test Plan:
1. Reset then req=0000 for 5 cycles → grant=0000, busy=0, s1s0=00 throughout.
2. req=0100 from IDLE → next cycle grant=0100, s1s0=10, busy=1. req drops to 0000 → next cycle grant=0000, busy=0, s1s0 stays 10.
3. req=1111 held with MAX_HOLD=8, done=0 → grants 0001,0010,0100,1000,0001, each lasting exactly 8 cycles. No zero-grant cycle between tenures; s1s0 cycles through 00,01,10,11.
4. req=1010 and grant on requester 1; pulse done at hold_cnt=2 → next cycle grant=1000, s1s0=11. Pulsing done again then grants 0010 (round-robin wrap).
5. Only req[2]=1 held continuously, MAX_HOLD=4 → grant=0100 re-issued after each 4-cycle timeout (hold_cnt resets, busy never drops).
6. req=1111 mid-grant on requester 3; assert rst for 1 cycle → next edge grant=0000, s1s0=00, busy=0, ptr=0. After rst falls, the next grant is 0001.
